// File: rtl/sender_pkg.sv
// Shared definitions for the sender-side ARQ logic.
// Holds the scheduler state encoding and the default timeout/retry
// constants so the sender top level and its testbench agree.
package sender_pkg;

    localparam int unsigned ARQ_STATE_W        = 3;
    localparam int unsigned ARQ_TIMEOUT_CYCLES = 200000;
    localparam int unsigned ARQ_MAX_RETRIES    = 3;
    localparam int unsigned ARQ_TMR_W          = 18;
    localparam int unsigned ARQ_RTY_W          = 2;

    typedef enum logic [ARQ_STATE_W-1:0] {
        ST_IDLE     = 3'd0,
        ST_SEND     = 3'd1,
        ST_WAIT_ACK = 3'd2,
        ST_RETRANS  = 3'd3,
        ST_DONE     = 3'd4,
        ST_FAIL     = 3'd5
    } arq_state_e;

endpackage

// File: rtl/arq_timer.sv
// Loadable up-counter with clear, enable and terminal-count flag.
// Counts up while enabled and parks at TIMEOUT_CYCLES-1 (never wraps).
// Ports:
//   clk_i      system clock
//   rst_i      synchronous active-high reset
//   clr_i      synchronous clear to zero (wins over load/enable)
//   ld_i       load ld_val_i
//   ld_val_i   value to load
//   en_i       count enable
//   tc_o       count == TIMEOUT_CYCLES-1
module arq_timer #(
    parameter int unsigned TMR_W          = 18,
    parameter int unsigned TIMEOUT_CYCLES = 200000
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr_i,
    input  logic             ld_i,
    input  logic [TMR_W-1:0] ld_val_i,
    input  logic             en_i,
    output logic             tc_o
);

    logic [TMR_W-1:0] cnt_q;
    logic [TMR_W-1:0] cnt_d;

    assign tc_o = (cnt_q == TMR_W'(TIMEOUT_CYCLES - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (ld_i) begin
            cnt_d = ld_val_i;
        end else if (en_i && !tc_o) begin
            cnt_d = cnt_q + TMR_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/arq_sched.sv
// Stop-and-wait ARQ scheduler for the sender path: first transmission,
// ACK wait, timeout/NAK-driven replay from the line FIFO, final release.
// Ports:
//   i_clk, i_rst       clock, synchronous active-high reset
//   i_arq_en           ARQ enable (0 = fire-and-forget)
//   i_frame_start      new frame accepted (pulse)
//   i_frame_end        last byte of frame on line (pulse)
//   i_ack_valid/good   decoded ACK (good=1) or NAK (good=0)
//   o_map_hold         stall mapper
//   o_retrans_req      replay request pulse
//   o_read_line_fifo   transmit path sources line FIFO
//   o_send_complete    flush line FIFO pulse
//   o_fail             sticky frame-drop flag
//   o_retry_cnt        retries used on current frame
//   o_drop_cnt         dropped frames, saturating
module arq_sched
    import sender_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = ARQ_TIMEOUT_CYCLES,
    parameter int unsigned MAX_RETRIES    = ARQ_MAX_RETRIES,
    parameter int unsigned TMR_W          = ARQ_TMR_W,
    parameter int unsigned RTY_W          = ARQ_RTY_W
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_arq_en,
    input  logic             i_frame_start,
    input  logic             i_frame_end,
    input  logic             i_ack_valid,
    input  logic             i_ack_good,
    output logic             o_map_hold,
    output logic             o_retrans_req,
    output logic             o_read_line_fifo,
    output logic             o_send_complete,
    output logic             o_fail,
    output logic [RTY_W-1:0] o_retry_cnt,
    output logic [7:0]       o_drop_cnt
);

    arq_state_e       state_q, state_d;
    logic [RTY_W-1:0] retry_q, retry_d;
    logic [7:0]       drop_q;
    logic             hold_q, rtx_q, rd_q, sc_q, fail_q;
    logic             tmr_tc;

    // Timer runs only while waiting; any other state holds it at zero,
    // so every WAIT_ACK entry starts from 0.
    arq_timer #(
        .TMR_W          (TMR_W),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timer (
        .clk_i    (i_clk),
        .rst_i    (i_rst),
        .clr_i    (state_q != ST_WAIT_ACK),
        .ld_i     (1'b0),
        .ld_val_i ('0),
        .en_i     (state_q == ST_WAIT_ACK),
        .tc_o     (tmr_tc)
    );

    always_comb begin
        state_d = state_q;
        retry_d = retry_q;
        unique case (state_q)
            ST_IDLE:     if (i_frame_start) state_d = ST_SEND;
            ST_SEND:     if (i_frame_end) state_d = i_arq_en ? ST_WAIT_ACK : ST_DONE;
            ST_WAIT_ACK: begin
                // Good ACK beats NAK beats timeout.
                if (i_ack_valid && i_ack_good) begin
                    state_d = ST_DONE;
                end else if (!i_arq_en) begin
                    state_d = ST_DONE;
                end else if (i_ack_valid || tmr_tc) begin
                    state_d = (retry_q < RTY_W'(MAX_RETRIES)) ? ST_RETRANS : ST_FAIL;
                end
            end
            ST_RETRANS:  if (i_frame_end) state_d = ST_WAIT_ACK;
            ST_DONE,
            ST_FAIL:     state_d = ST_IDLE;
            default:     state_d = ST_IDLE;
        endcase

        if (state_d == ST_RETRANS && state_q != ST_RETRANS) begin
            retry_d = retry_q + RTY_W'(1);
        end
        if (state_q == ST_DONE || state_q == ST_FAIL) begin
            retry_d = '0;
        end
    end

    // Level outputs are registered from the next state so they line up with
    // the state they describe; send_complete is registered from the current
    // DONE/FAIL state, one cycle later.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
            retry_q <= '0;
            drop_q  <= '0;
            hold_q  <= 1'b0;
            rtx_q   <= 1'b0;
            rd_q    <= 1'b0;
            sc_q    <= 1'b0;
            fail_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            retry_q <= retry_d;
            hold_q  <= (state_d == ST_WAIT_ACK) || (state_d == ST_RETRANS);
            rtx_q   <= (state_d == ST_RETRANS) && (state_q != ST_RETRANS);
            rd_q    <= (state_d == ST_RETRANS);
            sc_q    <= (state_q == ST_DONE) || (state_q == ST_FAIL);
            if (state_q == ST_FAIL) begin
                fail_q <= 1'b1;
                if (drop_q != 8'hFF) drop_q <= drop_q + 8'd1;
            end
        end
    end

    assign o_map_hold       = hold_q;
    assign o_retrans_req    = rtx_q;
    assign o_read_line_fifo = rd_q;
    assign o_send_complete  = sc_q;
    assign o_fail           = fail_q;
    assign o_retry_cnt      = retry_q;
    assign o_drop_cnt       = drop_q;

endmodule

// File: tb/tb_arq_sched.sv
module tb_arq_sched;
    import sender_pkg::*;

    localparam int unsigned T   = 64;
    localparam int unsigned RTY = ARQ_RTY_W;

    logic clk = 1'b0;
    logic rst, en, st, fe, av, ag;
    logic hold, rtx, rd, sc, fail;
    logic [RTY-1:0] rty;
    logic [7:0] drop;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    arq_sched #(
        .TIMEOUT_CYCLES (T),
        .MAX_RETRIES    (ARQ_MAX_RETRIES),
        .TMR_W          (ARQ_TMR_W),
        .RTY_W          (RTY)
    ) dut (
        .i_clk            (clk),
        .i_rst            (rst),
        .i_arq_en         (en),
        .i_frame_start    (st),
        .i_frame_end      (fe),
        .i_ack_valid      (av),
        .i_ack_good       (ag),
        .o_map_hold       (hold),
        .o_retrans_req    (rtx),
        .o_read_line_fifo (rd),
        .o_send_complete  (sc),
        .o_fail           (fail),
        .o_retry_cnt      (rty),
        .o_drop_cnt       (drop)
    );

    typedef struct {
        logic rst, en, st, fe, av, ag;
        logic hold, rtx, rd, sc, fail;
        logic [RTY-1:0] rty;
        logic [7:0] drop;
    } vec_t;

    function automatic vec_t mk(logic r, logic e, logic s, logic f, logic v, logic g,
                                logic h, logic x, logic d, logic c, logic l,
                                logic [RTY-1:0] y, logic [7:0] p);
        vec_t t;
        t.rst = r; t.en = e; t.st = s; t.fe = f; t.av = v; t.ag = g;
        t.hold = h; t.rtx = x; t.rd = d; t.sc = c; t.fail = l; t.rty = y; t.drop = p;
        return t;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Apply current inputs over one rising edge, then sample outputs.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        st = 1'b1; cyc(); st = 1'b0;
    endtask

    task automatic pulse_end();
        fe = 1'b1; cyc(); fe = 1'b0;
    endtask

    task automatic ack(input logic good);
        av = 1'b1; ag = good; cyc(); av = 1'b0; ag = 1'b0;
    endtask

    function automatic int outs();
        return int'({hold, rtx, rd, sc, fail, rty, drop});
    endfunction

    vec_t tbl[21];
    int   n;
    logic seen;

    initial begin
        rst = 1'b1; en = 1'b0; st = 1'b0; fe = 1'b0; av = 1'b0; ag = 1'b0;
        #2;

        //              rst en st fe av ag  hold rtx rd sc fail rty drop
        tbl[0]  = mk(1, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0); // reset
        tbl[1]  = mk(0, 1, 0, 0, 1, 1,  0, 0, 0, 0, 0, 0, 0); // stray ACK in IDLE
        tbl[2]  = mk(0, 1, 1, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0); // start -> SEND
        tbl[3]  = mk(0, 1, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0);
        tbl[4]  = mk(0, 1, 0, 1, 0, 0,  1, 0, 0, 0, 0, 0, 0); // end -> WAIT_ACK
        tbl[5]  = mk(0, 1, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0, 0);
        tbl[6]  = mk(0, 1, 0, 0, 1, 0,  1, 1, 1, 0, 0, 1, 0); // NAK -> RETRANS
        tbl[7]  = mk(0, 1, 0, 0, 0, 0,  1, 0, 1, 0, 0, 1, 0);
        tbl[8]  = mk(0, 1, 1, 0, 1, 1,  1, 0, 1, 0, 0, 1, 0); // start/ACK ignored
        tbl[9]  = mk(0, 1, 0, 1, 0, 0,  1, 0, 0, 0, 0, 1, 0); // end -> WAIT_ACK
        tbl[10] = mk(0, 1, 0, 0, 1, 1,  0, 0, 0, 0, 0, 1, 0); // ACK -> DONE
        tbl[11] = mk(0, 1, 0, 0, 0, 0,  0, 0, 0, 1, 0, 0, 0); // complete pulse
        tbl[12] = mk(0, 1, 0, 1, 0, 0,  0, 0, 0, 0, 0, 0, 0); // end in IDLE ignored
        tbl[13] = mk(0, 0, 1, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0); // ARQ off: start
        tbl[14] = mk(0, 0, 0, 1, 0, 0,  0, 0, 0, 0, 0, 0, 0); // end -> DONE
        tbl[15] = mk(0, 0, 0, 0, 0, 0,  0, 0, 0, 1, 0, 0, 0); // complete 2 after end
        tbl[16] = mk(0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0);
        tbl[17] = mk(0, 1, 1, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0);
        tbl[18] = mk(0, 1, 0, 1, 0, 0,  1, 0, 0, 0, 0, 0, 0);
        tbl[19] = mk(0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0); // disable while waiting
        tbl[20] = mk(0, 1, 0, 0, 0, 0,  0, 0, 0, 1, 0, 0, 0);

        for (int i = 0; i < 21; i++) begin
            rst = tbl[i].rst; en = tbl[i].en; st = tbl[i].st;
            fe = tbl[i].fe; av = tbl[i].av; ag = tbl[i].ag;
            cyc();
            chk($sformatf("vec%0d", i), outs(),
                int'({tbl[i].hold, tbl[i].rtx, tbl[i].rd, tbl[i].sc,
                      tbl[i].fail, tbl[i].rty, tbl[i].drop}));
        end
        rst = 1'b0; en = 1'b1; st = 1'b0; fe = 1'b0; av = 1'b0; ag = 1'b0;
        cyc();

        // Clean ACK 50 cycles after end.
        pulse_start();
        pulse_end();
        seen = 1'b0;
        for (int i = 0; i < 49; i++) begin
            cyc();
            if (rtx) seen = 1'b1;
        end
        chk("clean_hold", int'(hold), 1);
        ack(1'b1);
        chk("clean_sc_lat1", int'(sc), 0);
        cyc();
        chk("clean_sc_lat2", int'(sc), 1);
        chk("clean_rty", int'(rty), 0);
        chk("clean_no_rtx", int'(seen), 0);
        cyc();
        chk("clean_sc_once", int'(sc), 0);

        // Timeout-driven retransmission.
        pulse_start();
        pulse_end();
        n = 0;
        for (int i = 0; i < 200; i++) begin
            cyc();
            n++;
            if (rtx) break;
        end
        chk("tmo_latency", n, int'(T));
        chk("tmo_rd", int'(rd), 1);
        chk("tmo_rty", int'(rty), 1);
        for (int i = 0; i < 10; i++) cyc();
        chk("tmo_rd_hold", int'({rd, hold, rtx}), 3'b110);
        pulse_end();
        chk("tmo_rd_drop", int'({rd, hold}), 2'b01);
        ack(1'b1);
        cyc();
        chk("tmo_sc", int'({sc, rty}), int'({1'b1, RTY'(0)}));
        cyc();

        // Good ACK on the exact timeout cycle.
        pulse_start();
        pulse_end();
        seen = 1'b0;
        for (int i = 0; i < int'(T) - 1; i++) begin
            cyc();
            if (rtx) seen = 1'b1;
        end
        ack(1'b1);
        chk("coin_no_rtx", int'({seen, rtx, hold}), 0);
        cyc();
        chk("coin_sc", int'({sc, rty}), int'({1'b1, RTY'(0)}));
        cyc();

        // NAK exhaustion.
        pulse_start();
        pulse_end();
        for (int k = 1; k <= int'(ARQ_MAX_RETRIES); k++) begin
            ack(1'b0);
            chk($sformatf("nak%0d_rtx", k), int'({rtx, rd}), 2'b11);
            chk($sformatf("nak%0d_rty", k), int'(rty), k);
            cyc();
            pulse_end();
        end
        ack(1'b0);
        chk("nak_fail_entry", int'({rtx, hold, sc}), 0);
        cyc();
        chk("nak_fail_out", outs(), int'({5'b00011, RTY'(0), 8'd1}));
        pulse_start();
        pulse_end();
        chk("nak_next_frame", int'(hold), 1);
        ack(1'b1);
        cyc();
        chk("nak_next_sc", int'({sc, fail, drop}), int'({2'b11, 8'd1}));
        cyc();

        // Reset in the middle of RETRANS.
        pulse_start();
        pulse_end();
        ack(1'b0);
        chk("rst_pre", int'(rd), 1);
        rst = 1'b1; cyc(); rst = 1'b0;
        chk("rst_outs", outs(), 0);
        pulse_end();
        chk("rst_idle", outs(), 0);
        cyc();
        chk("rst_no_sc", outs(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
